// File: rtl/bubble_pkg.sv
// ---------------------------------------------------------------------------
// bubble_pkg
// Shared definitions for the bubble_dmem data memory. It holds the default
// geometry constants and the FSM state encoding used by the controller.
// ---------------------------------------------------------------------------
package bubble_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DEPTH  = 64;

  // IDLE: can accept a request. WAIT: counting read latency.
  // RESP: response is presented until it is consumed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/bubble_dmem_array.sv
// ---------------------------------------------------------------------------
// bubble_dmem_array
// Word-organised storage with byte-lane write enables. Both the write and
// the read are synchronous. The array has no reset, so its contents survive
// a controller reset.
//
// Ports:
//   clk    - clock, rising edge
//   addr   - word index, shared by the read and write paths
//   we     - write strobe; lanes are gated by be
//   be     - byte-lane enables, one bit per byte of wdata
//   wdata  - write data
//   re     - read strobe; rdata captures mem[addr] and then holds it
//   rdata  - registered read data
// ---------------------------------------------------------------------------
module bubble_dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = 6
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      addr,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write into the storage array.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (be[i]) begin
          mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Read data is captured only on a read strobe and held afterwards, so a
  // multi-cycle latency sees the word as it was on the strobe edge.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bubble_dmem.sv
// ---------------------------------------------------------------------------
// bubble_dmem
// Single-outstanding data memory with valid/ready request and response
// channels and a configurable read latency. Misaligned or out-of-range
// requests are answered with rsp_err=1 and never touch the array.
//
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   req_valid/req_ready   - request handshake (ready only while IDLE)
//   req_we                - 1 = write, 0 = read
//   req_addr              - byte address
//   req_wdata, req_be     - write data and byte-lane enables
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata             - read data, zero unless a good read is presented
//   rsp_err               - request was misaligned or out of range
// ---------------------------------------------------------------------------
module bubble_dmem
  import bubble_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned NB        = DATA_W / 8;
  localparam int unsigned LANE_BITS = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so a memory that fills the whole address space still
  // compares correctly.
  localparam logic [ADDR_W:0]   MEM_BYTES = (ADDR_W+1)'(DEPTH) * (ADDR_W+1)'(NB);
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'((64'd1 << LANE_BITS) - 64'd1);

  // Illegal geometry or latency stops elaboration.
  if ((RD_LAT < 1) || (RD_LAT > 4) || (DATA_W == 0) || ((DATA_W % 8) != 0) ||
      (DEPTH == 0) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_param
    $error("bubble_dmem: illegal parameter combination");
  end

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic misaligned;
    logic out_of_range;
    misaligned   = |(a & LANE_MASK);
    out_of_range = ({1'b0, a} >= MEM_BYTES);
    return misaligned | out_of_range;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        rd_ok_q, rd_ok_d;

  logic              accept_s;
  logic              err_s;
  logic              arr_we_s;
  logic              arr_re_s;
  logic [IDX_W-1:0]  arr_idx_s;
  logic [DATA_W-1:0] arr_rdata_s;

  // Requests seen while rst is high are ignored, including for the array.
  assign accept_s  = req_valid && (state_q == IDLE) && !rst;
  assign err_s     = addr_bad(req_addr);
  assign arr_we_s  = accept_s &&  req_we && !err_s;
  assign arr_re_s  = accept_s && !req_we && !err_s;
  assign arr_idx_s = req_addr[LANE_BITS +: IDX_W];

  bubble_dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .addr  (arr_idx_s),
    .we    (arr_we_s),
    .be    (req_be),
    .wdata (req_wdata),
    .re    (arr_re_s),
    .rdata (arr_rdata_s)
  );

  // Next-state logic: accept in IDLE, count latency in WAIT, hold in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_ok_d = rd_ok_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          err_d   = err_s;
          rd_ok_d = !req_we && !err_s;
          if (req_we || (RD_LAT == 1)) begin
            state_d = RESP;
            cnt_d   = 3'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(RD_LAT - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Leaving at a count of 1 makes rsp_valid rise RD_LAT cycles after
        // the accept edge.
        if (cnt_q <= 3'd1) begin
          state_d = RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d   = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
          rd_ok_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        err_d   = 1'b0;
        rd_ok_d = 1'b0;
      end
    endcase
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  // All outputs decode registered state; rdata is forced to zero unless a
  // good read is being presented.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) && err_q;
  assign rsp_rdata = ((state_q == RESP) && rd_ok_q) ? arr_rdata_s : {DATA_W{1'b0}};

endmodule

// File: tb/tb_bubble_dmem.sv
// ---------------------------------------------------------------------------
// tb_bubble_dmem
// Three default-geometry instances with RD_LAT = 1, 2, 3. Expected responses
// come from a bench-side memory model and are queued at the accept edge, then
// compared in order when each response handshake is seen.
// ---------------------------------------------------------------------------
module tb_bubble_dmem;

  typedef struct packed {
    logic [1:0]  k;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = 3'b000;
  logic [2:0]  req_ready;
  logic [2:0]  req_we = 3'b000;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready = 3'b111;
  logic [31:0] rsp_rdata [3];
  logic [2:0]  rsp_err;

  logic [31:0] mdl [3][64];
  exp_t        exp_q [$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bubble_dmem #(.RD_LAT(g + 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bench model: decide the response at the accept edge and update memory.
  task automatic model_accept(input int k, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    bit   err;
    err    = (addr[1:0] != 2'b00) || (addr >= 32'h100);
    e.k    = 2'(k);
    e.err  = err;
    e.data = 32'h0;
    if (!err && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mdl[k][addr[7:2]][i*8 +: 8] = wdata[i*8 +: 8];
      end
    end else if (!err) begin
      e.data = mdl[k][addr[7:2]];
    end
    exp_q.push_back(e);
  endtask

  // Present one request and return one #1 after its accept edge.
  task automatic send(input int k, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    bit acc = 1'b0;
    @(posedge clk); #1;
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
    req_wdata[k] = wdata; req_be[k] = be;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      if (req_ready[k] && !rst) begin
        acc = 1'b1;
        model_accept(k, we, addr, wdata, be);
      end
      @(posedge clk); #1;
    end
    req_valid[k] = 1'b0;
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  // Called right after an accept: rsp_valid must appear exactly lat cycles later.
  task automatic lat_check(input int k, input int lat);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        check("wait_rsp_valid", 64'(rsp_valid[k]), 64'd0);
        check("wait_req_ready", 64'(req_ready[k]), 64'd0);
      end else begin
        check("lat_rsp_valid", 64'(rsp_valid[k]), 64'd1);
      end
    end
  endtask

  // Response monitor and idle-zero check on every instance.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst && !rsp_valid[k]) check("rdata_zero_idle", 64'(rsp_rdata[k]), 64'd0);
      if (!rst && rsp_valid[k] && rsp_ready[k]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid[k]), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_inst",  64'(k),            64'(e.k));
          check("rsp_err",   64'(rsp_err[k]),   64'(e.err));
          check("rsp_rdata", 64'(rsp_rdata[k]), 64'(e.data));
        end
      end
    end
  end

  initial begin
    int acc_cyc [4];
    int n;
    logic [31:0] raddr [4];
    for (int k = 0; k < 3; k++) begin
      req_addr[k] = 32'h0; req_wdata[k] = 32'h0; req_be[k] = 4'h0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_req_ready", 64'(req_ready[k]), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid[k]), 64'd0);
      check("rst_rsp_rdata", 64'(rsp_rdata[k]), 64'd0);
      check("rst_rsp_err",   64'(rsp_err[k]),   64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // RD_LAT=1: full write, read back.
    send(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    lat_check(0, 1);
    check("wr_rsp_err", 64'(rsp_err[0]), 64'd0);
    send(0, 1'b0, 32'h10, 32'h0, 4'h0);
    lat_check(0, 1);
    check("rd_deadbeef", 64'(rsp_rdata[0]), 64'hDEADBEEF);

    // A write presented during reset is ignored.
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10;
    req_wdata[0] = 32'h11111111; req_be[0] = 4'hF;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; req_valid[0] = 1'b0;
    send(0, 1'b0, 32'h10, 32'h0, 4'h0);

    // Partial and empty byte enables.
    send(0, 1'b1, 32'h10, 32'h000000AA, 4'h1);
    send(0, 1'b0, 32'h10, 32'h0, 4'h0);
    lat_check(0, 1);
    check("rd_deadbeaa", 64'(rsp_rdata[0]), 64'hDEADBEAA);
    send(0, 1'b1, 32'h10, 32'h55555555, 4'h0);
    send(0, 1'b0, 32'h10, 32'h0, 4'h0);

    // Errors and the last word.
    send(0, 1'b1, 32'h12, 32'h12345678, 4'hF);
    lat_check(0, 1);
    check("misaligned_err", 64'(rsp_err[0]), 64'd1);
    send(0, 1'b0, 32'h10, 32'h0, 4'h0);
    send(0, 1'b0, 32'h100, 32'h0, 4'h0);
    lat_check(0, 1);
    check("oor_err",   64'(rsp_err[0]),   64'd1);
    check("oor_rdata", 64'(rsp_rdata[0]), 64'd0);
    send(0, 1'b1, 32'hFC, 32'hA5A5C3C3, 4'hF);
    send(0, 1'b0, 32'hFC, 32'h0, 4'h0);
    lat_check(0, 1);
    check("last_word", 64'(rsp_rdata[0]), 64'hA5A5C3C3);

    // RD_LAT=3: latency, back-pressure, release.
    send(2, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    rsp_ready[2] = 1'b0;
    send(2, 1'b0, 32'h20, 32'h0, 4'h0);
    lat_check(2, 3);
    @(negedge clk);
    check("hold_valid", 64'(rsp_valid[2]), 64'd1);
    check("hold_rdata", 64'(rsp_rdata[2]), 64'hCAFEF00D);
    check("hold_ready", 64'(req_ready[2]), 64'd0);
    @(posedge clk); #1;
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    check("release_valid", 64'(rsp_valid[2]), 64'd1);
    @(negedge clk);
    check("idle_valid", 64'(rsp_valid[2]), 64'd0);
    check("idle_ready", 64'(req_ready[2]), 64'd1);

    // Write accepted, then reset while its response is pending.
    @(posedge clk); #1;
    rsp_ready[2] = 1'b0;
    send(2, 1'b1, 32'h24, 32'h0BADF00D, 4'hF);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready[2] = 1'b1;
    @(negedge clk);
    check("rst_resp_valid", 64'(rsp_valid[2]), 64'd0);
    check("rst_resp_ready", 64'(req_ready[2]), 64'd1);

    // Reset during WAIT discards the read.
    send(2, 1'b0, 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    check("in_wait_valid", 64'(rsp_valid[2]), 64'd0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_valid", 64'(rsp_valid[2]), 64'd0);
      check("post_rst_ready", 64'(req_ready[2]), 64'd1);
    end
    send(2, 1'b0, 32'h24, 32'h0, 4'h0);
    lat_check(2, 3);
    check("write_survives_rst", 64'(rsp_rdata[2]), 64'h0BADF00D);

    // RD_LAT=2: req_valid held, accepts every 3 cycles.
    send(1, 1'b1, 32'h00, 32'h01010101, 4'hF);
    send(1, 1'b1, 32'h04, 32'h02020202, 4'hF);
    send(1, 1'b1, 32'h08, 32'h03030303, 4'hF);
    send(1, 1'b1, 32'h0C, 32'h04040404, 4'hF);
    raddr[0] = 32'h00; raddr[1] = 32'h04; raddr[2] = 32'h08; raddr[3] = 32'h0C;
    n = 0;
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = raddr[0]; req_be[1] = 4'h0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        acc_cyc[n] = cyc;
        model_accept(1, 1'b0, raddr[n], 32'h0, 4'h0);
        n++;
      end
      @(posedge clk); #1;
      if (n < 4) req_addr[1] = raddr[n];
    end
    req_valid[1] = 1'b0;
    check("b2b_accepts", 64'(n), 64'd4);
    for (int i = 1; i < n; i++) begin
      check("b2b_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);
    end

    // Drain outstanding responses.
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
